// File: rtl/serial_unload_register.sv
// Parallel-load, serial-unload register with a valid/ready bit stream.
// Word flow: IDLE captures, SHIFT emits WIDTH bits, DONE pulses once.
module serial_unload_register #(
    parameter int WIDTH     = 12,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld,
    input  logic [WIDTH-1:0]         pin,
    input  logic                     ready,
    output logic                     sout,
    output logic                     sout_valid,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shifted;
    logic             xfer;
    logic             last;

    assign xfer = (state == SHIFT) && ready;
    assign last = (bit_idx == LAST);

    // Shift toward the output end, zero-filling behind.
    generate
        if (MSB_FIRST) begin : g_msb
            assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (ld) state_nx = SHIFT;
            SHIFT:   if (xfer && last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            bit_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ld) begin
                        sreg    <= pin;
                        bit_idx <= '0;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        sreg    <= sreg_shifted;
                        bit_idx <= last ? '0 : bit_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sout       = 1'b0;
        sout_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            SHIFT: begin
                sout       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
                sout_valid = 1'b1;
                busy       = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/serial_unload_register.md
SERIAL_UNLOAD_REGISTER -- requirements
Module: serial_unload_register

Interface
REQ-001 Parameter WIDTH, default 12: bit width of the captured word; legal range 2..16.
REQ-002 Parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 ld  input  1  capture request; sampled only in state IDLE.
REQ-006 pin  input  WIDTH  parallel word to serialize; sampled on the edge where ld is accepted.
REQ-007 ready  input  1  consumer accepts the current bit this cycle.
REQ-008 sout  output  1  current serial bit.
REQ-009 sout_valid  output  1  sout holds a valid bit.
REQ-010 busy  output  1  high in SHIFT and DONE.
REQ-011 done  output  1  one-cycle pulse after the last bit transfers.
REQ-012 bit_idx  output  clog2(WIDTH)  index of bits already transferred in the current word, 0..WIDTH-1.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE, with ld=1 at an edge: shift register <= pin, bit_idx <= 0, next state SHIFT.
REQ-015 In IDLE, with ld=0: state and the shift register hold; sout_valid=0, busy=0.
REQ-016 In SHIFT, sout_valid SHALL be 1 and sout SHALL equal the shift register's MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0), combinationally from the register.
REQ-017 A transfer SHALL occur on an edge where sout_valid=1 and ready=1.
  - on a transfer, the shift register shifts by one toward the output end, zero-filling the vacated bit
  - on a transfer, bit_idx increments by 1
REQ-018 In SHIFT with ready=0: the shift register, bit_idx and sout SHALL hold unchanged; no bit is dropped or repeated.
REQ-019 A transfer with bit_idx=WIDTH-1 SHALL move the FSM to DONE; bit_idx returns to 0.
REQ-020 In DONE, done=1 and sout_valid=0 for exactly one cycle; the next state is unconditionally IDLE.
REQ-021 ld asserted in SHIFT or DONE SHALL be ignored: no recapture and no queuing.
REQ-022 Changes on pin after capture SHALL NOT affect the bits in flight.
REQ-023 Minimum latency SHALL be 1 cycle from the ld edge to the first sout_valid.
REQ-024 Minimum word period SHALL be WIDTH+2 cycles with ready tied high: WIDTH shift cycles, 1 DONE cycle, 1 IDLE capture cycle.
REQ-025 Outside SHIFT, sout SHALL be 0.

Reset
REQ-026 While rst=1 at an edge:
  - state SHALL be IDLE
  - shift register and bit_idx SHALL be 0
  - sout, sout_valid, busy and done SHALL be 0 in the following cycle
REQ-027 rst SHALL take priority over ld and ready on the same edge.
REQ-028 A reset mid-word SHALL abort the word; the partial word is discarded and no done pulse is produced.
REQ-029 After rst deasserts, the first ld SHALL be accepted in the very next cycle.

Verification
REQ-030 WIDTH=12, MSB_FIRST=1, ready=1; ld with pin=12'hA5C -> sout sequence 1,0,1,0,0,1,0,1,1,1,0,0 on 12 consecutive cycles. done pulses in the cycle after the 12th bit; busy high for 13 cycles.
REQ-031 MSB_FIRST=0, pin=12'h001, ready=1 -> first bit 1, then eleven 0s, then done.
REQ-032 pin=12'hFFF; ready low for 3 cycles after bit 4 -> sout_valid stays 1, bit_idx holds at 4, sout holds 1 for 3 cycles. All 12 bits are delivered exactly once; the total word takes 17 cycles.
REQ-033 ld re-asserted with pin=12'h000 during SHIFT of 12'hFFF -> all twelve bits are still 1 and only one done pulse occurs.
REQ-034 rst asserted at bit_idx=6 of pin=12'h3C3 -> the next cycle shows IDLE, sout_valid=0, done=0. A following ld with pin=12'h800 yields 1 then eleven 0s.
REQ-035 Back-to-back words 12'h123 and 12'h456, with ld held high -> the second capture occurs in the IDLE cycle after DONE. The bit streams are contiguous apart from the 2-cycle gap.
